reg_adcfifo_multich_reader: RTL and testbench

Parametrised register-bus read engine for multi-channel ADC sample FIFOs. Sits between the per-channel ADC sample FIFOs and the USB register interface. It fetches samples round-robin from the enabled channels, packs them into a byte-wide prefetch buffer (full-resolution or 8-bit low-res), and returns one byte per host read of the stream address. It also maintains a delivered-byte counter and a saturating underflow counter.

---
 rtl/reg_adcfifo_multich_reader_if.sv | 28 ++
 rtl/reg_adcfifo_multich_reader.sv | 215 +++++++++++++++++++++
 tb/tb_reg_adcfifo_multich_reader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_adcfifo_multich_reader_if.sv
// Register-bus bundle between the USB register host and the ADC FIFO reader.
//   reg_address  : register address
//   reg_bytecnt  : byte index within the addressed register
//   reg_datai    : write data
//   reg_datao    : read data (combinational from the reader)
//   reg_read     : read strobe, level, held for at least one cycle
//   reg_write    : write strobe
// master = register host, slave = reader.
interface reg_adcfifo_multich_reader_if #(
  parameter int pBYTECNT_SIZE = 7
);
  logic [7:0]               reg_address;
  logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
  logic [7:0]               reg_datai;
  logic [7:0]               reg_datao;
  logic                     reg_read;
  logic                     reg_write;

  modport master (
    output reg_address, reg_bytecnt, reg_datai, reg_read, reg_write,
    input  reg_datao
  );

  modport slave (
    input  reg_address, reg_bytecnt, reg_datai, reg_read, reg_write,
    output reg_datao
  );
endinterface

// File: rtl/reg_adcfifo_multich_reader.sv
// Multi-channel ADC FIFO read engine on the USB register bus.
// Fetches samples round-robin from the enabled channel FIFOs, packs them into
// a byte-wide prefetch buffer (two bytes per sample, or one byte in low-res
// mode) and hands one byte out per host read of the stream address. Keeps a
// 32-bit delivered-byte counter and a saturating 8-bit underflow counter.
// Ports:
//   clk_usb      : the only clock
//   reset_i      : asynchronous active-high reset
//   bus          : register bus (slave side)
//   fifo_empty   : per-channel FIFO empty flags
//   fifo_dout    : per-channel sample data, valid the cycle after fifo_rd_en
//   fifo_rd_en   : registered one-hot FIFO pop strobes
//   capture_done : status bit, readable in the control register
module reg_adcfifo_multich_reader #(
  parameter int         pBYTECNT_SIZE        = 7,
  parameter int         pCHANNELS            = 2,
  parameter int         pSAMPLE_WIDTH        = 12,
  parameter int         pPREFETCH_DEPTH      = 4,
  parameter logic [7:0] pADCREAD_ADDR        = 8'h03,
  parameter logic [7:0] pADC_READ_CTRL       = 8'h04,
  parameter logic [7:0] pFIFO_READ_COUNT     = 8'h05,
  parameter logic [7:0] pFIFO_UNDERFLOW_COUNT = 8'h06
) (
  input  logic                               clk_usb,
  input  logic                               reset_i,
  reg_adcfifo_multich_reader_if.slave        bus,
  input  logic [pCHANNELS-1:0]               fifo_empty,
  input  logic [pCHANNELS*pSAMPLE_WIDTH-1:0] fifo_dout,
  output logic [pCHANNELS-1:0]               fifo_rd_en,
  input  logic                               capture_done
);
  localparam int PTR_W  = (pCHANNELS > 1) ? $clog2(pCHANNELS) : 1;
  localparam int BUF_AW = $clog2(pPREFETCH_DEPTH);
  localparam int CNT_W  = BUF_AW + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RD, S_LATCH} state_t;

  state_t                   state, state_nxt;
  ptr_t                     ptr, ptr_nxt;
  logic [pCHANNELS-1:0]     rd_en_nxt;
  logic [pCHANNELS-1:0]     mask;
  logic                     low_res, lat_low_res, clear_q;
  logic                     read_q, empty_q;
  logic [CNT_W-1:0]         count, free, bps_now, push_n, pop_n;
  logic [BUF_AW-1:0]        wr_ptr, wr_ptr_p1, rd_ptr;
  logic [7:0]               mem [pPREFETCH_DEPTH];
  logic [31:0]              read_count;
  logic [7:0]               uf_count;
  logic [pBYTECNT_SIZE-1:0] bytecnt;
  logic                     flush, wr_ctrl1, stream_sel;
  logic                     rd_rise, rd_fall, empty_now, empty_seen;
  logic                     push, pop;
  logic [pSAMPLE_WIDTH-1:0] sample;
  logic [15:0]              sample16;
  logic [7:0]               byte_lo, byte_hi;
  logic                     unused_datai;

  assign bytecnt      = bus.reg_bytecnt;
  assign unused_datai = ^bus.reg_datai;

  function automatic ptr_t first_enabled(input logic [pCHANNELS-1:0] m);
    first_enabled = '0;
    for (int i = pCHANNELS - 1; i >= 0; i--)
      if (m[i]) first_enabled = ptr_t'(i);
  endfunction

  // Scan downwards so the nearest enabled channel after p wins; offset
  // pCHANNELS lands back on p itself when it is the only enabled channel.
  function automatic ptr_t next_enabled(input ptr_t p, input logic [pCHANNELS-1:0] m);
    int idx;
    next_enabled = p;
    for (int i = pCHANNELS; i >= 1; i--) begin
      idx = (int'(p) + i) % pCHANNELS;
      if (m[idx]) next_enabled = ptr_t'(idx);
    end
  endfunction

  // Register decode and read-strobe edge detection.
  assign flush      = bus.reg_write && (bus.reg_address == pADC_READ_CTRL) && (bytecnt == '0);
  assign wr_ctrl1   = bus.reg_write && (bus.reg_address == pADC_READ_CTRL) &&
                      (bytecnt == pBYTECNT_SIZE'(1));
  assign stream_sel = (bus.reg_address == pADCREAD_ADDR);
  assign rd_rise    = bus.reg_read && stream_sel && !read_q;
  assign rd_fall    = read_q && !bus.reg_read && stream_sel;
  assign empty_now  = (count == '0);
  // Emptiness is judged once at the rising edge and held for the whole strobe,
  // so a push landing mid-strobe cannot turn an underflow into a real pop.
  assign empty_seen = rd_rise ? empty_now : empty_q;
  assign pop        = rd_fall && !empty_q && !flush;
  assign push       = (state == S_LATCH) && !flush;

  assign free      = CNT_W'(pPREFETCH_DEPTH) - count;
  assign bps_now   = low_res ? CNT_W'(1) : CNT_W'(2);
  assign push_n    = push ? (lat_low_res ? CNT_W'(1) : CNT_W'(2)) : '0;
  assign pop_n     = CNT_W'(pop);
  assign wr_ptr_p1 = wr_ptr + 1'b1;

  // Byte packing of the sample latched from the selected channel.
  assign sample   = fifo_dout[int'(ptr)*pSAMPLE_WIDTH +: pSAMPLE_WIDTH];
  assign sample16 = 16'(sample);
  assign byte_lo  = lat_low_res ? sample[pSAMPLE_WIDTH-1 -: 8] : sample16[7:0];
  assign byte_hi  = sample16[15:8];

  // Fetch FSM, next-state logic.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    rd_en_nxt = '0;
    case (state)
      S_IDLE:  if (|mask) begin
                 ptr_nxt   = first_enabled(mask);
                 state_nxt = S_WAIT;
               end
      S_WAIT:  if (!fifo_empty[ptr] && (free >= bps_now)) state_nxt = S_RD;
      S_RD:    state_nxt = S_LATCH;
      S_LATCH: begin
                 ptr_nxt   = next_enabled(ptr, mask);
                 state_nxt = S_WAIT;
               end
      default: state_nxt = S_IDLE;
    endcase
    if (flush) begin
      state_nxt = S_IDLE;
      ptr_nxt   = '0;
    end
    if (state_nxt == S_RD) rd_en_nxt = pCHANNELS'(1) << ptr_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      state       <= S_IDLE;
      ptr         <= '0;
      fifo_rd_en  <= '0;
      lat_low_res <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      fifo_rd_en <= rd_en_nxt;
      // Packing mode is frozen at the WAIT->RD decision for this sample.
      if (state == S_WAIT && state_nxt == S_RD) lat_low_res <= low_res;
    end
  end

  // Control registers, buffer bookkeeping and counters.
  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      mask       <= pCHANNELS'(1);
      low_res    <= 1'b0;
      clear_q    <= 1'b0;
      read_q     <= 1'b0;
      empty_q    <= 1'b1;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      read_count <= '0;
      uf_count   <= '0;
    end else begin
      if (flush) mask <= bus.reg_datai[pCHANNELS-1:0];
      if (wr_ctrl1) low_res <= bus.reg_datai[0];
      clear_q <= wr_ctrl1 && bus.reg_datai[1];
      read_q  <= bus.reg_read && stream_sel;
      if (rd_rise) empty_q <= empty_now;

      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        count <= count + push_n - pop_n;
        if (push) wr_ptr <= wr_ptr + BUF_AW'(push_n);
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end

      if (clear_q)  read_count <= '0;
      else if (pop) read_count <= read_count + 32'd1;

      if (clear_q) uf_count <= '0;
      else if (rd_rise && empty_now && (uf_count != 8'hFF)) uf_count <= uf_count + 8'd1;
    end
  end

  // NOTE: the prefetch storage has no reset; occupancy and pointers decide
  // what is valid, so clearing the array would add logic for nothing.
  always_ff @(posedge clk_usb) begin
    if (push) begin
      mem[wr_ptr] <= byte_lo;
      if (!lat_low_res) mem[wr_ptr_p1] <= byte_hi;
    end
  end

  // Read data mux; zero unless a read strobe is active.
  always_comb begin
    bus.reg_datao = 8'h00;
    if (bus.reg_read) begin
      case (bus.reg_address)
        pADCREAD_ADDR:
          if (!empty_seen) bus.reg_datao = mem[rd_ptr];
        pADC_READ_CTRL:
          if (bytecnt == '0) bus.reg_datao = 8'(mask);
          else if (bytecnt == pBYTECNT_SIZE'(1))
            bus.reg_datao = {5'b0, capture_done, 1'b0, low_res};
        pFIFO_READ_COUNT:
          if (int'(bytecnt) < 4) bus.reg_datao = read_count[bytecnt[1:0]*8 +: 8];
        pFIFO_UNDERFLOW_COUNT:
          if (bytecnt == '0) bus.reg_datao = uf_count;
        default: bus.reg_datao = 8'h00;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_adcfifo_multich_reader.sv
module tb_reg_adcfifo_multich_reader;
  localparam logic [7:0] A_STREAM = 8'h03;
  localparam logic [7:0] A_CTRL   = 8'h04;
  localparam logic [7:0] A_COUNT  = 8'h05;
  localparam logic [7:0] A_UF     = 8'h06;

  logic        clk_usb = 1'b0;
  logic        reset_i = 1'b1;
  logic [1:0]  fifo_empty = 2'b11;
  logic [23:0] fifo_dout = '0;
  logic [1:0]  fifo_rd_en;
  logic        capture_done = 1'b0;

  reg_adcfifo_multich_reader_if #(.pBYTECNT_SIZE(7)) bus ();

  reg_adcfifo_multich_reader dut (
    .clk_usb      (clk_usb),
    .reset_i      (reset_i),
    .bus          (bus),
    .fifo_empty   (fifo_empty),
    .fifo_dout    (fifo_dout),
    .fifo_rd_en   (fifo_rd_en),
    .capture_done (capture_done)
  );

  always #5 clk_usb = ~clk_usb;

  logic [11:0] ch0_q[$];
  logic [11:0] ch1_q[$];
  logic [7:0]  exp_q[$];
  int pulses0 = 0;
  int pulses1 = 0;
  int n_checks = 0;
  int n_pass = 0;

  // Channel FIFO models: pop on rd_en, data valid the following cycle.
  always @(posedge clk_usb) begin
    if (fifo_rd_en[0]) begin
      pulses0++;
      if (ch0_q.size() > 0) fifo_dout[11:0] <= ch0_q.pop_front();
    end
    if (fifo_rd_en[1]) begin
      pulses1++;
      if (ch1_q.size() > 0) fifo_dout[23:12] <= ch1_q.pop_front();
    end
    fifo_empty <= {ch1_q.size() == 0, ch0_q.size() == 0};
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_usb);
  endtask

  task automatic host_write(input logic [7:0] a, input int bc, input logic [7:0] d);
    @(negedge clk_usb);
    bus.reg_address = a;
    bus.reg_bytecnt = 7'(bc);
    bus.reg_datai   = d;
    bus.reg_write   = 1'b1;
    @(negedge clk_usb);
    bus.reg_write   = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a, input int bc, output logic [7:0] d);
    @(negedge clk_usb);
    bus.reg_address = a;
    bus.reg_bytecnt = 7'(bc);
    bus.reg_read    = 1'b1;
    #1 d = bus.reg_datao;
    @(negedge clk_usb);
    bus.reg_read    = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [7:0] a, input int bc,
                           input logic [7:0] exp);
    logic [7:0] d;
    host_read(a, bc, d);
    check(tag, {24'h0, d}, {24'h0, exp});
  endtask

  // Stream read compared against the next scoreboard entry.
  task automatic stream_read(input string tag);
    logic [7:0] d;
    logic [7:0] e;
    host_read(A_STREAM, 0, d);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check(tag, {24'h0, d}, {24'h0, e});
  endtask

  task automatic drain_fifos();
    ch0_q.delete();
    ch1_q.delete();
    cycles(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int got;
    bus.reg_address = 8'h00;
    bus.reg_bytecnt = '0;
    bus.reg_datai   = 8'h00;
    bus.reg_read    = 1'b0;
    bus.reg_write   = 1'b0;
    cycles(3);
    reset_i = 1'b0;
    cycles(2);

    // Reset state.
    check("rst_rd_en", {30'h0, fifo_rd_en}, 32'h0);
    check("rst_datao_idle", {24'h0, bus.reg_datao}, 32'h0);
    check_reg("rst_mask", A_CTRL, 0, 8'h01);
    capture_done = 1'b1;
    check_reg("ctrl_capture_done", A_CTRL, 1, 8'h04);
    capture_done = 1'b0;
    check_reg("rst_count0", A_COUNT, 0, 8'h00);
    check_reg("rst_uf", A_UF, 0, 8'h00);
    check_reg("unmapped", 8'h7F, 0, 8'h00);

    // Full-resolution stream from channel 0.
    @(negedge clk_usb);
    ch0_q.push_back(12'hABC); ch0_q.push_back(12'h123);
    exp_q.push_back(8'hBC); exp_q.push_back(8'h0A);
    exp_q.push_back(8'h23); exp_q.push_back(8'h01);
    cycles(20);
    bus.reg_address = A_STREAM;
    #1 check("datao_no_strobe", {24'h0, bus.reg_datao}, 32'h0);
    for (int i = 0; i < 4; i++) stream_read($sformatf("full_res_b%0d", i));
    check("full_res_pulses0", pulses0, 2);
    check_reg("full_res_count", A_COUNT, 0, 8'h04);

    // Low-res two-channel interleave; upper mask bits ignored.
    host_write(A_CTRL, 0, 8'hFF);
    check_reg("mask_clip", A_CTRL, 0, 8'h03);
    host_write(A_CTRL, 1, 8'h01);
    @(negedge clk_usb);
    ch0_q.push_back(12'h111); ch0_q.push_back(12'h222);
    ch1_q.push_back(12'h333); ch1_q.push_back(12'h444);
    exp_q.push_back(8'h11); exp_q.push_back(8'h33);
    exp_q.push_back(8'h22); exp_q.push_back(8'h44);
    cycles(30);
    for (int i = 0; i < 4; i++) stream_read($sformatf("low_res_b%0d", i));
    check_reg("low_res_count", A_COUNT, 0, 8'h08);

    // clear_counts is self-clearing and zeroes the counter.
    host_write(A_CTRL, 1, 8'h03);
    cycles(3);
    check_reg("clear_count", A_COUNT, 0, 8'h00);
    check_reg("clear_reads0", A_CTRL, 1, 8'h01);

    // Underflow with everything empty, then saturation.
    host_write(A_CTRL, 1, 8'h00);
    host_write(A_CTRL, 0, 8'h01);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h00);
      stream_read($sformatf("underflow_b%0d", i));
    end
    check_reg("underflow_3", A_UF, 0, 8'h03);
    check_reg("underflow_count", A_COUNT, 0, 8'h00);
    for (int i = 0; i < 300; i++) host_read(A_STREAM, 0, d);
    check_reg("underflow_sat", A_UF, 0, 8'hFF);
    check_reg("underflow_count_b3", A_COUNT, 3, 8'h00);

    // Engine waits on an empty enabled channel rather than skipping it.
    host_write(A_CTRL, 0, 8'h03);
    pulses0 = 0; pulses1 = 0;
    @(negedge clk_usb);
    ch0_q.push_back(12'h101); ch0_q.push_back(12'h202);
    ch0_q.push_back(12'h303); ch0_q.push_back(12'h404);
    exp_q.push_back(8'h01); exp_q.push_back(8'h01);
    exp_q.push_back(8'h55); exp_q.push_back(8'h05);
    cycles(20);
    check("hold_pulses0", pulses0, 1);
    check("hold_pulses1", pulses1, 0);
    @(negedge clk_usb);
    ch1_q.push_back(12'h555);
    cycles(20);
    check("resume_pulses1", pulses1, 1);
    check("resume_pulses0", pulses0, 1);
    for (int i = 0; i < 4; i++) stream_read($sformatf("interleave_b%0d", i));
    drain_fifos();

    // Prefetch full back-pressure.
    host_write(A_CTRL, 0, 8'h01);
    exp_q.delete();
    cycles(2);
    pulses0 = 0;
    @(negedge clk_usb);
    ch0_q.push_back(12'h0A1); ch0_q.push_back(12'h0B2); ch0_q.push_back(12'h0C3);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h00);
    exp_q.push_back(8'hB2); exp_q.push_back(8'h00);
    exp_q.push_back(8'hC3); exp_q.push_back(8'h00);
    cycles(20);
    check("full_pulses", pulses0, 2);
    stream_read("full_rd0");
    cycles(20);
    check("free1_no_fetch", pulses0, 2);
    stream_read("full_rd1");
    cycles(20);
    check("free2_fetch", pulses0, 3);
    for (int i = 2; i < 6; i++) stream_read($sformatf("full_rd%0d", i));

    // Asynchronous reset while a pop strobe is high.
    @(negedge clk_usb);
    ch0_q.push_back(12'h777);
    got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      @(negedge clk_usb);
      if (fifo_rd_en[0]) got = 1;
    end
    check("reach_rd_state", got, 1);
    reset_i = 1'b1;
    #1 check("async_rd_en_drop", {30'h0, fifo_rd_en}, 32'h0);
    ch0_q.delete();
    exp_q.delete();
    cycles(2);
    reset_i = 1'b0;
    cycles(3);
    check_reg("post_rst_mask", A_CTRL, 0, 8'h01);
    check_reg("post_rst_count", A_COUNT, 0, 8'h00);
    check_reg("post_rst_uf", A_UF, 0, 8'h00);
    exp_q.push_back(8'h00);
    stream_read("post_rst_read");
    check_reg("post_rst_uf1", A_UF, 0, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
